mor1kx_branch_predictor_gshare_multi: RTL and testbench

Parametrised gshare conditional-branch predictor, successor to the fixed-size predictors. It has configurable pattern-table depth, history length and counter width. After reset, a sequential init engine clears the pattern table. Sits between decode (prediction) and execute (resolution), and also provides a saturating mispredict statistic counter.

---
 rtl/mor1kx_branch_predictor_gshare_multi.sv | 142 ++++++++++++++
 tb/tb_mor1kx_branch_predictor_gshare_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_branch_predictor_gshare_multi.sv
// Parametrised gshare conditional-branch predictor with a sequential pattern-table
// init walk after reset and a saturating mispredict statistic counter.
module mor1kx_branch_predictor_gshare_multi #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TABLE_ADDR_WIDTH     = 8,
    parameter int HISTORY_WIDTH        = 8,
    parameter int COUNTER_WIDTH        = 2,
    parameter int PC_LSB               = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            padv_decode_i,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
    output logic                            predicted_flag_o,
    input  logic                            prev_op_brcond_i,
    input  logic                            prev_predicted_flag_i,
    input  logic                            flag_i,
    input  logic                            execute_bf_i,
    input  logic                            execute_bnf_i,
    output logic                            branch_mispredict_o,
    input  logic                            stat_clr_i,
    output logic [15:0]                     mispredict_cnt_o,
    output logic                            init_done_o
);
    localparam int ENTRIES = 1 << TABLE_ADDR_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] CNT_WNT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                      state_q, state_d;
    logic [TABLE_ADDR_WIDTH:0]   init_idx_q, init_idx_d;
    logic [HISTORY_WIDTH-1:0]    ghr_q, ghr_d, ghr_shift;
    logic [TABLE_ADDR_WIDTH-1:0] pend_idx_q, pend_idx_d;
    logic [15:0]                 mis_cnt_q, mis_cnt_d;
    logic [COUNTER_WIDTH-1:0]    pht_q [ENTRIES];

    logic [TABLE_ADDR_WIDTH-1:0] hist_idx, lookup_idx, pht_waddr;
    logic [COUNTER_WIDTH-1:0]    lookup_ctr, upd_ctr_old, upd_ctr_new, pht_wdata;
    logic                        taken_pred, upd_en, upd_taken, pht_we;
    logic                        unused_in;

    generate
        if (HISTORY_WIDTH >= TABLE_ADDR_WIDTH) begin : g_hist_trunc
            assign hist_idx = ghr_q[TABLE_ADDR_WIDTH-1:0];
        end else begin : g_hist_ext
            assign hist_idx = {{(TABLE_ADDR_WIDTH - HISTORY_WIDTH){1'b0}}, ghr_q};
        end
        if (HISTORY_WIDTH == 1) begin : g_ghr_one
            assign ghr_shift = upd_taken;
        end else begin : g_ghr_multi
            assign ghr_shift = {ghr_q[HISTORY_WIDTH-2:0], upd_taken};
        end
    endgenerate

    // Only the indexing slice of the PC matters; bnf is implied by !bf on execute.
    assign unused_in = ^{brn_pc_i, execute_bnf_i};

    assign lookup_idx          = brn_pc_i[PC_LSB +: TABLE_ADDR_WIDTH] ^ hist_idx;
    assign lookup_ctr          = pht_q[lookup_idx];
    assign taken_pred          = (state_q == ST_RUN) & lookup_ctr[COUNTER_WIDTH-1];
    assign predicted_flag_o    = op_bf_i ? taken_pred : (op_bnf_i ? ~taken_pred : 1'b0);
    assign branch_mispredict_o = prev_op_brcond_i & (flag_i != prev_predicted_flag_i);
    assign init_done_o         = (state_q == ST_RUN);
    assign mispredict_cnt_o    = mis_cnt_q;

    assign upd_en      = padv_decode_i & prev_op_brcond_i & (state_q == ST_RUN);
    assign upd_taken   = execute_bf_i ? flag_i : ~flag_i;
    assign upd_ctr_old = pht_q[pend_idx_q];

    always_comb begin
        upd_ctr_new = upd_ctr_old;
        if (upd_taken) begin
            if (upd_ctr_old != CNT_MAX) upd_ctr_new = upd_ctr_old + COUNTER_WIDTH'(1);
        end else begin
            if (upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - COUNTER_WIDTH'(1);
        end
    end

    // The init index runs one past the last entry so RUN starts a cycle after the final write.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        pht_we     = 1'b0;
        pht_waddr  = pend_idx_q;
        pht_wdata  = upd_ctr_new;
        ghr_d      = ghr_q;
        case (state_q)
            ST_INIT: begin
                if (!init_idx_q[TABLE_ADDR_WIDTH]) begin
                    pht_we     = 1'b1;
                    pht_waddr  = init_idx_q[TABLE_ADDR_WIDTH-1:0];
                    pht_wdata  = CNT_WNT;
                    init_idx_d = init_idx_q + (TABLE_ADDR_WIDTH + 1)'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (upd_en) begin
                    pht_we = 1'b1;
                    ghr_d  = ghr_shift;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        pend_idx_d = pend_idx_q;
        if (padv_decode_i & (op_bf_i | op_bnf_i)) pend_idx_d = lookup_idx;
        mis_cnt_d = mis_cnt_q;
        if (stat_clr_i)
            mis_cnt_d = '0;
        else if (padv_decode_i & branch_mispredict_o & ~&mis_cnt_q)
            mis_cnt_d = mis_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
            pend_idx_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
            pend_idx_q <= pend_idx_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Table contents survive rst_n; the init walk is what clears them.
    always_ff @(posedge clk) begin
        if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    end

endmodule

// File: tb/tb_mor1kx_branch_predictor_gshare_multi.sv
// Directed bench for the gshare predictor (TABLE_ADDR_WIDTH=8, HISTORY_WIDTH=3, COUNTER_WIDTH=2).
module tb_mor1kx_branch_predictor_gshare_multi;
    logic        clk, rst_n;
    logic        padv, op_bf, op_bnf, pred;
    logic [31:0] pc;
    logic        prev_brcond, prev_pred, flag, ex_bf, ex_bnf, mispredict, stat_clr, done;
    logic [15:0] cnt;
    int          errors = 0;
    int          checks = 0;

    mor1kx_branch_predictor_gshare_multi #(
        .OPTION_OPERAND_WIDTH(32), .TABLE_ADDR_WIDTH(8), .HISTORY_WIDTH(3),
        .COUNTER_WIDTH(2), .PC_LSB(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .padv_decode_i(padv), .op_bf_i(op_bf), .op_bnf_i(op_bnf),
        .brn_pc_i(pc), .predicted_flag_o(pred), .prev_op_brcond_i(prev_brcond),
        .prev_predicted_flag_i(prev_pred), .flag_i(flag), .execute_bf_i(ex_bf),
        .execute_bnf_i(ex_bnf), .branch_mispredict_o(mispredict), .stat_clr_i(stat_clr),
        .mispredict_cnt_o(cnt), .init_done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic set_in(input logic p, input logic bf, input logic bnf, input logic [31:0] a,
                          input logic rs, input logic xbf, input logic xbnf, input logic fl,
                          input logic pp);
        @(negedge clk);
        padv = p; op_bf = bf; op_bnf = bnf; pc = a;
        prev_brcond = rs; ex_bf = xbf; ex_bnf = xbnf; flag = fl; prev_pred = pp;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stat_clr = 1'b0;
        padv = 0; op_bf = 0; op_bnf = 0; pc = '0;
        prev_brcond = 0; prev_pred = 0; flag = 0; ex_bf = 0; ex_bnf = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%h exp=0000", cnt); end
        op_bf = 1'b1; #1;
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL init_bf_pred got=%b exp=0", pred); end
        op_bf = 1'b0; op_bnf = 1'b1; #1;
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL init_bnf_pred got=%b exp=1", pred); end
        op_bnf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            @(posedge clk);
            #1;
            if (i <= 256) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL init_walk_done edge=%0d got=%b exp=0", i, done); end
            end else begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL init_done_rise got=%b exp=1", done); end
            end
        end
        set_in(0, 1, 0, 32'h200, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL wnt_bf got=%b exp=0", pred); end
        set_in(0, 0, 1, 32'h3FC, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL wnt_bnf got=%b exp=1", pred); end
    endtask

    // PC 0x100 -> index 0x40; the decode PC is re-chosen each cycle so index^GHR stays 0x40.
    task automatic test_train;
        set_in(1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL train_c1 got=%b exp=0", pred); end
        set_in(1, 1, 0, 32'h100, 1, 1, 0, 1, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mis got=%b exp=1", mispredict); end
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL train_c2 got=%b exp=0", pred); end
        set_in(1, 1, 0, 32'h104, 1, 1, 0, 1, 1);
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL train_nomis got=%b exp=0", mispredict); end
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL train_c3 got=%b exp=1", pred); end
        checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL train_cnt1 got=%0d exp=1", cnt); end
        set_in(1, 1, 0, 32'h10C, 1, 1, 0, 1, 1);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL train_c4 got=%b exp=1", pred); end
        set_in(0, 1, 0, 32'h11C, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL train_sat got=%b exp=1", pred); end
        checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL train_cnt1b got=%0d exp=1", cnt); end
        set_in(1, 1, 0, 32'h11C, 1, 1, 0, 0, 1);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mis2 got=%b exp=1", mispredict); end
        set_in(0, 1, 0, 32'h118, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL train_dec1 got=%b exp=1", pred); end
        checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL train_cnt2 got=%0d exp=2", cnt); end
        set_in(1, 1, 0, 32'h118, 1, 1, 0, 0, 1);
        set_in(0, 1, 0, 32'h110, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL train_dec2 got=%b exp=0", pred); end
        checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL train_cnt3 got=%0d exp=3", cnt); end
        set_in(0, 0, 1, 32'h110, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL train_dec2_bnf got=%b exp=1", pred); end
    endtask

    // GHR enters at 3'b100; taken / not-taken / taken leaves 3'b101 and entry 0x14 at 2.
    task automatic test_ghr;
        set_in(1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL ghr_pre got=%b exp=0", pred); end
        set_in(1, 0, 0, 32'h0, 1, 1, 0, 1, 1);
        set_in(1, 0, 0, 32'h0, 1, 0, 1, 1, 1);
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL ghr_bnf_mis got=%b exp=0", mispredict); end
        set_in(1, 0, 0, 32'h0, 1, 1, 0, 1, 1);
        set_in(0, 1, 0, 32'h44, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL ghr_101_hit got=%b exp=1", pred); end
        set_in(0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL ghr_101_miss got=%b exp=0", pred); end
        set_in(0, 1, 0, 32'h10044, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL ghr_alias got=%b exp=1", pred); end
        checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL ghr_cnt got=%0d exp=3", cnt); end
    endtask

    task automatic test_stall;
        set_in(0, 1, 0, 32'h80, 1, 1, 0, 1, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL stall_mis got=%b exp=1", mispredict); end
        set_in(0, 1, 0, 32'h44, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL stall_ghr got=%b exp=1", pred); end
        checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", cnt); end
        set_in(1, 0, 0, 32'h0, 1, 1, 0, 1, 0);
        set_in(0, 1, 0, 32'h5C, 0, 0, 0, 0, 0);
        checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL count_inc got=%0d exp=4", cnt); end
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL count_upd got=%b exp=1", pred); end
    endtask

    task automatic test_stat_sat;
        set_in(1, 0, 0, 32'h0, 1, 1, 0, 1, 0);
        repeat (65531) @(posedge clk);
        #1;
        checks++; if (cnt !== 16'hFFFF) begin errors++; $display("FAIL stat_reach got=%h exp=ffff", cnt); end
        @(posedge clk); #1;
        checks++; if (cnt !== 16'hFFFF) begin errors++; $display("FAIL stat_sat got=%h exp=ffff", cnt); end
        @(negedge clk); stat_clr = 1'b1;
        @(posedge clk); #1;
        checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL stat_clr got=%h exp=0000", cnt); end
        @(negedge clk); stat_clr = 1'b0;
        @(posedge clk); #1;
        checks++; if (cnt !== 16'h1) begin errors++; $display("FAIL stat_after_clr got=%h exp=0001", cnt); end
        set_in(0, 0, 0, 32'h0, 1, 1, 0, 1, 0);
        @(posedge clk); #1;
        checks++; if (cnt !== 16'h1) begin errors++; $display("FAIL stat_nopadv got=%h exp=0001", cnt); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_cnt got=%h exp=0000", cnt); end
        padv = 1; op_bf = 1; op_bnf = 0; pc = 32'h50;
        prev_brcond = 1; ex_bf = 1; ex_bnf = 0; flag = 1; prev_pred = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            @(posedge clk);
            #1;
            if (i == 256) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL reinit_256 got=%b exp=0", done); end
            end
            if (i == 257) begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL reinit_257 got=%b exp=1", done); end
            end
        end
        padv = 0; op_bf = 0; prev_brcond = 0; ex_bf = 0; flag = 0; prev_pred = 0;
        set_in(0, 1, 0, 32'h50, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b0) begin errors++; $display("FAIL reinit_wnt got=%b exp=0", pred); end
        set_in(1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 32'h0, 1, 1, 0, 1, 1);
        set_in(0, 1, 0, 32'h104, 0, 0, 0, 0, 0);
        checks++; if (pred !== 1'b1) begin errors++; $display("FAIL reinit_ghr got=%b exp=1", pred); end
        checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reinit_cnt got=%h exp=0000", cnt); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_ghr();
        test_stall();
        test_stat_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
